// File: rtl/ccd_pkg.sv
// ccd_pkg: readout mode codes, sequencer states and field widths shared by the CCD sequencer.
package ccd_pkg;

    localparam int unsigned FLUSH_W = 4;
    localparam int unsigned EXP_W   = 24;

    // Codes must match the readout engine's mode decoder.
    localparam logic [1:0] MODE_CLEAN = 2'd0;
    localparam logic [1:0] MODE_1X1   = 2'd1;
    localparam logic [1:0] MODE_2X2   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH_REQ,
        S_FLUSH_WAIT,
        S_EXPOSE,
        S_READ_REQ,
        S_READ_WAIT
    } seq_state_e;

    function automatic logic [1:0] read_mode(input logic binning);
        return binning ? MODE_2X2 : MODE_1X1;
    endfunction

endpackage

// File: rtl/ccd_exposure_sequencer_ms_timer.sv
// ccd_ms_timer: millisecond prescaler plus 24-bit exposure down-counter.
module ccd_ms_timer
    import ccd_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [EXP_W-1:0] value,
    input  logic             abort,
    output logic             expired,
    output logic             tick
);

    localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    logic [PW-1:0]    pre_q;
    logic [EXP_W-1:0] cnt_q;

    assign tick    = (cnt_q != '0) && (pre_q == PW'(TICKS_PER_MS - 1));
    // Flags the final millisecond, so the tick that ends it can close the shutter on time.
    assign expired = cnt_q <= EXP_W'(1);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            pre_q <= '0;
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            cnt_q <= tick ? cnt_q - 1'b1 : cnt_q;
        end
    end

endmodule

// File: rtl/ccd_exposure_sequencer.sv
// ccd_exposure_sequencer: runs flush passes, a timed shutter exposure and one readout pass per host start.
// Define CCD_SEQ_WATCHDOG_EN to add a readout-start watchdog that raises seq_error.
module ccd_exposure_sequencer
    import ccd_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = 50000,
    parameter int unsigned WD_CYCLES    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    input  logic [FLUSH_W-1:0] cfg_flush_count,
    input  logic [EXP_W-1:0]   cfg_exposure_ms,
    input  logic               cfg_binning,
    output logic               ro_toggle,
    output logic [1:0]         ro_mode,
    input  logic               ro_busy,
    output logic               shutter_open,
    output logic               seq_busy,
    output logic               frame_done,
    output logic               seq_error
);

    if (TICKS_PER_MS < 1 || WD_CYCLES < 1) begin : g_bad_param
        $error("ccd_exposure_sequencer: TICKS_PER_MS and WD_CYCLES must be at least 1");
    end

    seq_state_e         state_q;
    logic [FLUSH_W-1:0] flush_q;
    logic [EXP_W-1:0]   exp_q;
    logic [1:0]         mode_q;
    logic               bin_q, aborted_q, toggle_q, shutter_q, busy_q, done_q;
    logic               in_req, in_hs, start_ok, go_idle, done_w, wd_fire;
    logic               tmr_load, tmr_abort, tmr_expired, tmr_tick;

    assign in_req   = (state_q == S_FLUSH_REQ) || (state_q == S_READ_REQ);
    assign in_hs    = in_req || (state_q == S_FLUSH_WAIT) || (state_q == S_READ_WAIT);
    assign start_ok = (state_q == S_IDLE) && cmd_start && !cmd_abort;
    // An aborted handshake may only leave once the engine has finished its pass.
    assign go_idle  = wd_fire || ((state_q == S_EXPOSE) && cmd_abort)
                   || (in_hs && !ro_busy && (cmd_abort || aborted_q || state_q == S_READ_WAIT));
    assign done_w   = (state_q == S_READ_WAIT) && !ro_busy && !cmd_abort && !aborted_q;

    assign tmr_load  = (start_ok && cfg_flush_count == '0)
                    || ((state_q == S_FLUSH_WAIT) && !ro_busy && !cmd_abort && !aborted_q
                        && flush_q == FLUSH_W'(1));
    assign tmr_abort = (state_q == S_EXPOSE) && cmd_abort;

    ccd_ms_timer #(
        .TICKS_PER_MS(TICKS_PER_MS)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  ((state_q == S_IDLE) ? cfg_exposure_ms : exp_q),
        .abort  (tmr_abort),
        .expired(tmr_expired),
        .tick   (tmr_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            flush_q   <= '0;
            exp_q     <= '0;
            bin_q     <= 1'b0;
            aborted_q <= 1'b0;
            toggle_q  <= 1'b0;
            mode_q    <= MODE_CLEAN;
            shutter_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (go_idle) begin
            state_q   <= S_IDLE;
            flush_q   <= '0;
            aborted_q <= 1'b0;
            toggle_q  <= 1'b0;
            mode_q    <= MODE_CLEAN;
            shutter_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= done_w;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_ok) begin
                    flush_q <= cfg_flush_count;
                    exp_q   <= cfg_exposure_ms;
                    bin_q   <= cfg_binning;
                    busy_q  <= 1'b1;
                    if (cfg_flush_count != '0) begin
                        state_q  <= S_FLUSH_REQ;
                        toggle_q <= !ro_busy;
                    end else if (cfg_exposure_ms != '0) begin
                        state_q   <= S_EXPOSE;
                        shutter_q <= 1'b1;
                    end else begin
                        state_q  <= S_READ_REQ;
                        mode_q   <= read_mode(cfg_binning);
                        toggle_q <= !ro_busy;
                    end
                end
                S_FLUSH_REQ, S_READ_REQ: begin
                    if (cmd_abort || aborted_q) begin
                        aborted_q <= 1'b1;
                        toggle_q  <= 1'b0;
                    end else if (toggle_q && ro_busy) begin
                        toggle_q <= 1'b0;
                        state_q  <= (state_q == S_FLUSH_REQ) ? S_FLUSH_WAIT : S_READ_WAIT;
                    end else if (!toggle_q) begin
                        toggle_q <= !ro_busy;
                    end
                end
                S_FLUSH_WAIT: begin
                    if (cmd_abort) begin
                        aborted_q <= 1'b1;
                    end else if (!ro_busy) begin
                        flush_q <= flush_q - 1'b1;
                        if (flush_q != FLUSH_W'(1)) begin
                            state_q  <= S_FLUSH_REQ;
                            toggle_q <= 1'b1;
                        end else if (exp_q != '0) begin
                            state_q   <= S_EXPOSE;
                            shutter_q <= 1'b1;
                        end else begin
                            state_q  <= S_READ_REQ;
                            mode_q   <= read_mode(bin_q);
                            toggle_q <= 1'b1;
                        end
                    end
                end
                S_EXPOSE: if (tmr_tick && tmr_expired) begin
                    state_q   <= S_READ_REQ;
                    shutter_q <= 1'b0;
                    mode_q    <= read_mode(bin_q);
                    toggle_q  <= !ro_busy;
                end
                S_READ_WAIT: if (cmd_abort) aborted_q <= 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CCD_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    assign wd_fire = in_req && toggle_q && !ro_busy && (wd_q == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (in_req && toggle_q && !ro_busy && !wd_fire) ? wd_q + 1'b1 : '0;
            err_q <= wd_fire || (err_q && !start_ok);
        end
    end

    assign seq_error = err_q;
`else
    assign wd_fire   = 1'b0;
    assign seq_error = 1'b0;
`endif

    assign ro_toggle    = toggle_q;
    assign ro_mode      = mode_q;
    assign shutter_open = shutter_q;
    assign seq_busy     = busy_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_ccd_exposure_sequencer.sv
// tb_ccd_exposure_sequencer: directed bench with a busy-for-20-cycles readout engine model and mode scoreboard.
module tb_ccd_exposure_sequencer;
    import ccd_pkg::*;

    localparam int TPM  = 4;
    localparam int WD   = 16;
    localparam int BUSY = 20;

    logic        clk = 1'b0, rst = 1'b1, cmd_start = 1'b0, cmd_abort = 1'b0;
    logic        cfg_binning = 1'b0, ro_busy = 1'b0;
    logic [3:0]  cfg_flush_count = '0;
    logic [23:0] cfg_exposure_ms = '0;
    logic        ro_toggle, shutter_open, seq_busy, frame_done, seq_error;
    logic [1:0]  ro_mode;

    int checks = 0, errors = 0;
    int done_cnt = 0, shut_cyc = 0, toggles = 0, stale_req = 0, busy_left = 0;
    int d0, s0, t0, n;
    bit model_en = 1'b1, cur_valid = 1'b0;
    logic [1:0] cur_mode = MODE_CLEAN;
    logic [1:0] exp_modes[$];

    ccd_exposure_sequencer #(.TICKS_PER_MS(TPM), .WD_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_flush_count(cfg_flush_count), .cfg_exposure_ms(cfg_exposure_ms),
        .cfg_binning(cfg_binning), .ro_toggle(ro_toggle), .ro_mode(ro_mode),
        .ro_busy(ro_busy), .shutter_open(shutter_open), .seq_busy(seq_busy),
        .frame_done(frame_done), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] fl, input logic [23:0] ex, input logic bn, input logic ab);
        cfg_flush_count = fl;
        cfg_exposure_ms = ex;
        cfg_binning     = bn;
        cmd_start       = 1'b1;
        cmd_abort       = ab;
        step();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
    endtask

    task automatic abort_pulse();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (seq_busy === 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk(tag, seq_busy, 0);
    endtask

    task automatic snap();
        d0 = done_cnt;
        s0 = shut_cyc;
        t0 = toggles;
    endtask

    // Readout engine model and output monitor; toggle starts are checked against the mode scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) done_cnt++;
            if (shutter_open) shut_cyc++;
            if (ro_busy) begin
                if (cur_valid) chk("mode_stable", ro_mode, cur_mode);
                busy_left--;
                if (busy_left == 0) ro_busy = 1'b0;
            end else if (stale_req != 0) begin
                ro_busy   = 1'b1;
                busy_left = stale_req;
                stale_req = 0;
                cur_valid = 1'b0;
            end else if (ro_toggle && model_en) begin
                toggles++;
                chk("toggle_expected", exp_modes.size() != 0, 1);
                if (exp_modes.size() != 0) chk("toggle_mode", ro_mode, exp_modes.pop_front());
                cur_mode  = ro_mode;
                cur_valid = 1'b1;
                ro_busy   = 1'b1;
                busy_left = BUSY;
            end
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_toggle", ro_toggle, 0);
        chk("rst_mode", ro_mode, MODE_CLEAN);
        chk("rst_shutter", shutter_open, 0);
        chk("rst_busy", seq_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_error", seq_error, 0);
        rst = 1'b0;
        step();

        // Full frame: two flushes, 3 ms exposure, 1x1 readout; cfg changes after start must be ignored.
        snap();
        exp_modes.push_back(MODE_CLEAN);
        exp_modes.push_back(MODE_CLEAN);
        exp_modes.push_back(MODE_1X1);
        start(4'd2, 24'd3, 1'b0, 1'b0);
        chk("t1_busy_lat", seq_busy, 1);
        chk("t1_toggle_lat", ro_toggle, 1);
        chk("t1_mode_clean", ro_mode, MODE_CLEAN);
        cfg_flush_count = 4'd7;
        cfg_exposure_ms = 24'd99;
        cfg_binning     = 1'b1;
        wait_idle("t1_idle", 600);
        step();
        chk("t1_toggles", toggles - t0, 3);
        chk("t1_shutter_cycles", shut_cyc - s0, 3 * TPM);
        chk("t1_frame_done", done_cnt - d0, 1);
        chk("t1_sb_empty", exp_modes.size(), 0);
        chk("t1_mode_idle", ro_mode, MODE_CLEAN);
        chk("t1_no_error", seq_error, 0);

        // No flush, no exposure, 2x2: immediate readout toggle.
        snap();
        exp_modes.push_back(MODE_2X2);
        start(4'd0, 24'd0, 1'b1, 1'b0);
        chk("t2_toggle_lat", ro_toggle, 1);
        chk("t2_mode", ro_mode, MODE_2X2);
        wait_idle("t2_idle", 100);
        step();
        chk("t2_shutter_cycles", shut_cyc - s0, 0);
        chk("t2_frame_done", done_cnt - d0, 1);

        // Abort five cycles into the exposure.
        snap();
        start(4'd0, 24'd10, 1'b0, 1'b0);
        chk("t3_shutter_open", shutter_open, 1);
        repeat (4) step();
        abort_pulse();
        chk("t3_shutter_closed", shutter_open, 0);
        chk("t3_idle", seq_busy, 0);
        repeat (5) step();
        chk("t3_shutter_cycles", shut_cyc - s0, 5);
        chk("t3_no_done", done_cnt - d0, 0);
        chk("t3_no_toggle", toggles - t0, 0);

        // Abort during the first flush pass.
        snap();
        exp_modes.push_back(MODE_CLEAN);
        start(4'd3, 24'd5, 1'b0, 1'b0);
        n = 0;
        while (!(ro_busy && !ro_toggle) && n < 10) begin
            step();
            n++;
        end
        chk("t4_in_flush_wait", ro_busy && !ro_toggle, 1);
        repeat (3) step();
        abort_pulse();
        chk("t4_waits_for_pass", seq_busy, 1);
        chk("t4_toggle_low", ro_toggle, 0);
        wait_idle("t4_idle", 60);
        repeat (30) step();
        chk("t4_toggles", toggles - t0, 1);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_no_shutter", shut_cyc - s0, 0);
        chk("t4_sb_empty", exp_modes.size(), 0);

        // Start while a stale pass is still running.
        snap();
        stale_req = 30;
        step();
        exp_modes.push_back(MODE_1X1);
        start(4'd0, 24'd0, 1'b0, 1'b0);
        chk("t5_busy", seq_busy, 1);
        chk("t5_toggle_held", ro_toggle, 0);
        repeat (10) step();
        chk("t5_toggle_still_held", ro_toggle, 0);
        n = 0;
        while (ro_toggle !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("t5_toggle_seen", ro_toggle, 1);
        wait_idle("t5_idle", 60);
        step();
        chk("t5_frame_done", done_cnt - d0, 1);

        // Start and abort together in IDLE: nothing starts.
        start(4'd1, 24'd1, 1'b0, 1'b1);
        chk("t6_abort_wins", seq_busy, 0);
        chk("t6_no_toggle", ro_toggle, 0);

        // Reset mid-exposure.
        start(4'd0, 24'd20, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("t7_rst_shutter", shutter_open, 0);
        chk("t7_rst_busy", seq_busy, 0);
        rst = 1'b0;
        step();

`ifdef CCD_SEQ_WATCHDOG_EN
        // Engine never responds: watchdog fires after WD cycles of toggle.
        snap();
        model_en = 1'b0;
        start(4'd0, 24'd0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40 && seq_busy; i++) begin
            if (ro_toggle) n++;
            step();
        end
        chk("wd_toggle_cycles", n, WD);
        chk("wd_error_set", seq_error, 1);
        chk("wd_toggle_low", ro_toggle, 0);
        chk("wd_idle", seq_busy, 0);
        chk("wd_no_done", done_cnt - d0, 0);
        model_en = 1'b1;
        exp_modes.push_back(MODE_1X1);
        start(4'd0, 24'd0, 1'b0, 1'b0);
        chk("wd_error_cleared", seq_error, 0);
        wait_idle("wd_recover_idle", 60);
        step();
        chk("wd_recover_done", done_cnt - d0, 1);
`endif

        chk("final_sb_empty", exp_modes.size(), 0);
        chk("final_error", seq_error, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
